gt_refclk_obufds: RTL



---
 rtl/gt_refclk_obufds.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gt_refclk_obufds.sv
// gt_refclk_obufds: behavioural transmit-side GT reference-clock output
// buffer. Optionally divides a GT-domain clock and drives it onto O/OB.
//
// Parameters:
//   REFCLK_EN_TX_PATH  0 parks the pair at O=0/OB=1 for good
//   CLK_DIVIDE         1 (gated pass-through) or even 2..16
//   CE_SYNC_STAGES     CEB synchronizer depth, 2..4
//
// Ports:
//   CLK     in   source clock (GT output clock)
//   RST     in   asynchronous reset, active-high
//   CEB     in   output enable, active-low, asynchronous to CLK
//   O       out  differential output, true leg
//   OB      out  differential output, complement leg
//   ACTIVE  out  high while running or draining a high phase
//   EDGE_CNT out [15:0] rising-edge counter, only with the
//                `GT_REFCLK_EDGE_CNT_EN macro defined
`timescale 1ns/1ps

module gt_refclk_obufds #(
    parameter bit REFCLK_EN_TX_PATH = 1'b1,
    parameter int CLK_DIVIDE        = 2,
    parameter int CE_SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEB,
    output logic        O,
    output logic        OB,
    output logic        ACTIVE
`ifdef GT_REFCLK_EDGE_CNT_EN
    ,
    output logic [15:0] EDGE_CNT
`endif
);

    generate
        if (!(CLK_DIVIDE == 1 ||
              (CLK_DIVIDE >= 2 && CLK_DIVIDE <= 16 &&
               CLK_DIVIDE % 2 == 0))) begin : g_bad_div
            $error("gt_refclk_obufds: illegal CLK_DIVIDE");
        end
        if (CE_SYNC_STAGES < 2 || CE_SYNC_STAGES > 4) begin : g_bad_sync
            $error("gt_refclk_obufds: illegal CE_SYNC_STAGES");
        end
    endgenerate

    localparam bit PASS = (CLK_DIVIDE == 1);
    // Last count of a half period; unused in pass-through mode.
    localparam logic [2:0] HALF_M1 =
        PASS ? 3'd0 : 3'(CLK_DIVIDE / 2 - 1);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    logic [CE_SYNC_STAGES-1:0] ceb_sync;
    logic                      ceb_s;
    state_t                    state;
    state_t                    state_nxt;
    logic [2:0]                cnt;
    logic [2:0]                cnt_nxt;
    logic                      o_reg;
    logic                      o_nxt;
    logic                      toggle;
    logic                      active;
    logic                      gate;

    // Flops start at 1 so the output stays disabled out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ceb_sync <= '1;
        end else begin
            ceb_sync <= {ceb_sync[CE_SYNC_STAGES-2:0], CEB};
        end
    end

    assign ceb_s  = ceb_sync[CE_SYNC_STAGES-1];
    assign toggle = (cnt == HALF_M1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        o_nxt     = o_reg;
        unique case (state)
            STOPPED: begin
                if (!ceb_s && REFCLK_EN_TX_PATH) begin
                    state_nxt = RUNNING;
                    cnt_nxt   = 3'd0;
                    o_nxt     = 1'b0;
                end
            end
            RUNNING: begin
                if (PASS) begin
                    if (ceb_s) begin
                        state_nxt = STOPPED;
                    end
                end else if (ceb_s && !o_reg) begin
                    // Truncating a low phase never produces a runt.
                    state_nxt = STOPPED;
                    cnt_nxt   = 3'd0;
                end else begin
                    if (toggle) begin
                        o_nxt   = ~o_reg;
                        cnt_nxt = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                    // A stop request landing on the falling edge
                    // itself finishes at once instead of draining.
                    if (ceb_s) begin
                        state_nxt = toggle ? STOPPED : STOPPING;
                    end
                end
            end
            STOPPING: begin
                // Divider keeps running so re-enable keeps phase.
                if (toggle) begin
                    o_nxt   = ~o_reg;
                    cnt_nxt = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
                if (!ceb_s) begin
                    state_nxt = RUNNING;
                end else if (toggle) begin
                    state_nxt = STOPPED;
                end
            end
            default: begin
                state_nxt = STOPPED;
                cnt_nxt   = 3'd0;
                o_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= STOPPED;
            cnt    <= 3'd0;
            o_reg  <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            o_reg  <= o_nxt;
            active <= (state_nxt != STOPPED);
        end
    end

    generate
        if (PASS) begin : g_pass
            // Gate moves only while CLK is low, so CLK & gate
            // can never emit a partial high phase.
            always_ff @(negedge CLK or posedge RST) begin
                if (RST) begin
                    gate <= 1'b0;
                end else begin
                    gate <= (state == RUNNING);
                end
            end
        end else begin : g_div
            assign gate = 1'b0;
        end
    endgenerate

    assign O      = PASS ? (CLK & gate) : o_reg;
    assign OB     = ~O;
    assign ACTIVE = active;

`ifdef GT_REFCLK_EDGE_CNT_EN
    logic [15:0] edge_cnt;
    logic        rise;

    assign rise = PASS ? gate : (!o_reg && o_nxt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= 16'd0;
        end else if (rise) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end

    assign EDGE_CNT = edge_cnt;
`endif

endmodule
